// File: rtl/gaussian_frame_ctrl_pkg.sv
// Shared types and helpers for the Gaussian frame sequencer.
// Holds the FSM encoding and the expected filtered-output count.
package gaussian_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of complete KxK windows in an h x w frame.
    function automatic int exp_out(input int h, input int w, input int k);
        return (h - k + 1) * (w - k + 1);
    endfunction

    localparam int EXP_OUT = exp_out(512, 640, 3);

endpackage

// File: rtl/gaussian_frame_ctrl_raster_counter.sv
// Raster position counter: position of the next pixel in the frame.
// Ports: clk_i, rst_i, clear_i (restart at 0,0), adv_i (pixel accepted),
//        row_o/col_o (current position), last_o (position is the final pixel).
module raster_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 512,
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    // Column wraps into the next row; the row never wraps, the frame
    // ends on the last pixel before it could.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for the 3x3 Gaussian filter: accepts one raster frame,
// drives matrix_clken/data_valid/start, counts filter outputs, checks total.
// Ports: clk_i, rst_i (sync, active-high), frame_start_i, pix_valid_i,
//   pix_ready_o, stall_i, matrix_clken_o, data_valid_o, start_o,
//   filt_ready_i, row_idx_o, col_idx_o, busy_o, frame_done_o,
//   out_count_o, count_err_o.
module gaussian_frame_ctrl
    import gaussian_frame_ctrl_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 512,
    parameter int KERNEL_SIZE = 3,
    parameter int FILT_LAT    = 2,
    parameter int CNT_W       = 10,
    parameter int OCNT_W      = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic              stall_i,
    output logic              matrix_clken_o,
    output logic              data_valid_o,
    output logic              start_o,
    input  logic              filt_ready_i,
    output logic [CNT_W-1:0]  row_idx_o,
    output logic [CNT_W-1:0]  col_idx_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [OCNT_W-1:0] out_count_o,
    output logic              count_err_o
);

    localparam int DR_W = $clog2(FILT_LAT + 1) + 1;
    localparam logic [DR_W-1:0]   DRAIN_END = DR_W'(FILT_LAT);
    localparam logic [CNT_W-1:0]  BORDER    = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [OCNT_W-1:0] EXP_CNT   =
        OCNT_W'(exp_out(IMG_H, IMG_W, KERNEL_SIZE));

    state_e            state_q;
    logic [DR_W-1:0]   drain_q;
    logic              busy_q;
    logic              start_q;
    logic              frame_done_q;
    logic              count_err_q;
    logic              matrix_clken_q;
    logic              data_valid_q;
    logic [CNT_W-1:0]  row_idx_q;
    logic [CNT_W-1:0]  col_idx_q;
    logic [OCNT_W-1:0] out_count_q;

    logic              accept;
    logic              arm;
    logic              in_window;
    logic              last_pix;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;

    assign pix_ready_o = (state_q == ST_RUN) && !stall_i;
    assign accept      = pix_valid_i && pix_ready_o;
    assign arm         = (state_q == ST_IDLE) && frame_start_i;
    // Only windows fully inside the frame are computed by the filter.
    assign in_window   = (row >= BORDER) && (col >= BORDER);

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_raster (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (arm),
        .adv_i   (accept),
        .row_o   (row),
        .col_o   (col),
        .last_o  (last_pix)
    );

    // Sequencer; the drain stage covers the filter latency so the last
    // ready pulse is counted before the completion check in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            count_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept && last_pix) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_END) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    start_q <= 1'b0;
                    if (out_count_q != EXP_CNT) begin
                        count_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            matrix_clken_q <= 1'b0;
            data_valid_q   <= 1'b1;
            row_idx_q      <= '0;
            col_idx_q      <= '0;
            out_count_q    <= '0;
        end else begin
            matrix_clken_q <= accept;
            data_valid_q   <= !(accept && in_window);
            if (arm) begin
                row_idx_q   <= '0;
                col_idx_q   <= '0;
                out_count_q <= '0;
            end else begin
                if (accept) begin
                    row_idx_q <= row;
                    col_idx_q <= col;
                end
                if (filt_ready_i && (state_q != ST_IDLE)
                    && (out_count_q != '1)) begin
                    out_count_q <= out_count_q + OCNT_W'(1);
                end
            end
        end
    end

    assign matrix_clken_o = matrix_clken_q;
    assign data_valid_o   = data_valid_q;
    assign start_o        = start_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign count_err_o    = count_err_q;
    assign row_idx_o      = row_idx_q;
    assign col_idx_o      = col_idx_q;
    assign out_count_o    = out_count_q;

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Testbench for gaussian_frame_ctrl on a 5x4 frame with a latency-2
// filter model; data_valid expectations are queued on each accept.
module tb_gaussian_frame_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int CW = 10;
    localparam int OW = 19;
    localparam int NPIX = W * H;
    localparam int EXP  = (H - K + 1) * (W - K + 1);
    localparam int LAT0 = NPIX + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic pix_valid = 1'b0;
    logic stall = 1'b0;
    logic filt_ready = 1'b0;
    logic sr0 = 1'b0;
    logic pix_ready, matrix_clken, data_valid, start;
    logic busy, frame_done, count_err;
    logic [CW-1:0] row_idx, col_idx;
    logic [OW-1:0] out_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int c0 = 0;
    int clk_cnt = 0;
    int dv0_cnt = 0;
    int mr, mc, lr, lc;
    int drop_req = 0;
    int drop_done = 0;
    bit dvq[$];
    bit mon_exp;

    gaussian_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .KERNEL_SIZE(K),
        .FILT_LAT(2), .CNT_W(CW), .OCNT_W(OW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
        .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
        .stall_i(stall), .matrix_clken_o(matrix_clken),
        .data_valid_o(data_valid), .start_o(start),
        .filt_ready_i(filt_ready), .row_idx_o(row_idx),
        .col_idx_o(col_idx), .busy_o(busy),
        .frame_done_o(frame_done), .out_count_o(out_count),
        .count_err_o(count_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: ready two cycles after a compute window; can drop one.
    always @(posedge clk) begin
        sr0 <= matrix_clken & ~data_valid;
        if (sr0 === 1'b1 && drop_req != drop_done) begin
            filt_ready <= 1'b0;
            drop_done  <= drop_done + 1;
        end else begin
            filt_ready <= (sr0 === 1'b1);
        end
    end

    // Scoreboard: every matrix_clken consumes one queued accept.
    always @(negedge clk) begin
        if (matrix_clken === 1'b1) begin
            clk_cnt = clk_cnt + 1;
            if (data_valid === 1'b0) dv0_cnt = dv0_cnt + 1;
            n_cmp = n_cmp + 1;
            if (dvq.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL sb_empty: matrix_clken=1 with no accept queued");
            end else begin
                mon_exp = dvq.pop_front();
                if (data_valid !== mon_exp) begin
                    n_err = n_err + 1;
                    $display("FAIL sb_data_valid: got %b want %b",
                             data_valid, mon_exp);
                end
            end
        end
    end

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        pix_valid = 1'b0;
        stall = 1'b0;
        mr = 0; mc = 0; lr = 0; lc = 0;
        clk_cnt = 0;
        dv0_cnt = 0;
        c0 = cyc;
    endtask

    task automatic feed(input int n, input int st_lo, input int st_hi,
                        input int fs_at);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_cmp = n_cmp + 1;
            if (row_idx !== CW'(lr) || col_idx !== CW'(lc)) begin
                n_err = n_err + 1;
                $display("FAIL idx c=%0d: got %0d,%0d want %0d,%0d",
                         c, row_idx, col_idx, lr, lc);
            end
            frame_start = (c == fs_at);
            pix_valid = 1'b1;
            stall = (c >= st_lo && c <= st_hi);
            #1;
            n_cmp = n_cmp + 1;
            if (pix_ready !== ~stall) begin
                n_err = n_err + 1;
                $display("FAIL pix_ready c=%0d: got %b want %b",
                         c, pix_ready, ~stall);
            end
            if (!stall) begin
                dvq.push_back(!(mr >= K - 1 && mc >= K - 1));
                lr = mr;
                lc = mc;
                if (mc == W - 1) begin
                    mc = 0;
                    mr = mr + 1;
                end else begin
                    mc = mc + 1;
                end
            end
        end
    endtask

    task automatic wait_done(output int pulses, output int lat,
                             output bit tmo);
        int after;
        pulses = 0;
        lat = -1;
        after = -1;
        for (int i = 0; i < 60 && after < 3; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                pulses = pulses + 1;
                lat = cyc - c0;
            end
            if (pulses > 0 && busy === 1'b0) after = after + 1;
            pix_valid = 1'b0;
            stall = 1'b0;
            frame_start = 1'b0;
        end
        tmo = (after < 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({busy, matrix_clken, data_valid, start, count_err} !== 5'b00100) begin
            n_err = n_err + 1;
            $display("FAIL reset_ctl: busy,clken,dv,start,err=%b want 00100",
                     {busy, matrix_clken, data_valid, start, count_err});
        end
        n_cmp = n_cmp + 1;
        if (out_count !== '0 || frame_done !== 1'b0 || pix_ready !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_misc: out_count=%0d done=%b ready=%b want 0",
                     out_count, frame_done, pix_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        int p, l;
        bit t;
        start_frame();
        feed(NPIX, -1, -1, -1);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || l != LAT0) begin
            n_err = n_err + 1;
            $display("FAIL frame_done: timeout=%b pulses=%0d lat=%0d want 0/1/%0d",
                     t, p, l, LAT0);
        end
        n_cmp = n_cmp + 1;
        if (clk_cnt != NPIX || dv0_cnt != EXP) begin
            n_err = n_err + 1;
            $display("FAIL frame_clken: clken=%0d dv0=%0d want %0d/%0d",
                     clk_cnt, dv0_cnt, NPIX, EXP);
        end
        n_cmp = n_cmp + 1;
        if (out_count !== OW'(EXP) || count_err !== 1'b0 || start !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL frame_count: out=%0d err=%b start=%b want %0d/0/0",
                     out_count, count_err, start, EXP);
        end
    endtask

    task automatic test_stall();
        int p, l;
        bit t;
        start_frame();
        feed(NPIX + 4, 4, 7, -1);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || l != LAT0 + 4) begin
            n_err = n_err + 1;
            $display("FAIL stall_done: timeout=%b pulses=%0d lat=%0d want 0/1/%0d",
                     t, p, l, LAT0 + 4);
        end
        n_cmp = n_cmp + 1;
        if (out_count !== OW'(EXP) || clk_cnt != NPIX) begin
            n_err = n_err + 1;
            $display("FAIL stall_count: out=%0d clken=%0d want %0d/%0d",
                     out_count, clk_cnt, EXP, NPIX);
        end
    endtask

    task automatic test_drop();
        int p, l;
        bit t;
        drop_req = drop_req + 1;
        start_frame();
        feed(NPIX, -1, -1, -1);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || out_count !== OW'(EXP - 1) || count_err !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL drop: tmo=%b pulses=%0d out=%0d err=%b want 0/1/%0d/1",
                     t, p, out_count, count_err, EXP - 1);
        end
        start_frame();
        feed(NPIX, -1, -1, -1);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || out_count !== OW'(EXP) || count_err !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL drop_sticky: tmo=%b pulses=%0d out=%0d err=%b want 0/1/%0d/1",
                     t, p, out_count, count_err, EXP);
        end
    endtask

    task automatic test_reset_mid();
        int p, l, seen;
        bit t;
        start_frame();
        feed(9, -1, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (busy !== 1'b0 || row_idx !== '0 || col_idx !== '0
            || count_err !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL mid_reset: busy=%b row=%0d col=%0d err=%b want 0",
                     busy, row_idx, col_idx, count_err);
        end
        rst = 1'b0;
        pix_valid = 1'b0;
        dvq.delete();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = seen + 1;
        end
        n_cmp = n_cmp + 1;
        if (seen != 0 || busy !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL mid_no_done: pulses=%0d busy=%b want 0/0", seen, busy);
        end
        start_frame();
        feed(NPIX, -1, -1, -1);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || l != LAT0 || out_count !== OW'(EXP)
            || count_err !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL mid_clean: tmo=%b p=%0d lat=%0d out=%0d err=%b",
                     t, p, l, out_count, count_err);
        end
    endtask

    task automatic test_restart_ignored();
        int p, l;
        bit t;
        start_frame();
        feed(NPIX, -1, -1, 7);
        wait_done(p, l, t);
        n_cmp = n_cmp + 1;
        if (t || p != 1 || l != LAT0 || out_count !== OW'(EXP)
            || clk_cnt != NPIX) begin
            n_err = n_err + 1;
            $display("FAIL restart_ign: tmo=%b p=%0d lat=%0d out=%0d clken=%0d",
                     t, p, l, out_count, clk_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_drop();
        test_reset_mid();
        test_restart_ignored();
        n_cmp = n_cmp + 1;
        if (dvq.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL sb_leftover: %0d queued accepts never seen", dvq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
